// File: rtl/obb_integrator.sv
// ============================================================================
// obb_integrator: per-frame OBB motion integrator with one shared adder.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module obb_integrator #(
    parameter int DT_SHIFT = 6,
    parameter int POS_MIN  = -60,
    parameter int POS_MAX  = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] pos_x_in,
    input  logic [31:0] pos_y_in,
    input  logic [31:0] vel_x_in,
    input  logic [31:0] vel_y_in,
    input  logic [9:0]  angle_in,
    input  logic [9:0]  omega_in,
    output logic        busy,
    output logic        wr_en,
    output logic [31:0] pos_x_out,
    output logic [31:0] pos_y_out,
    output logic [31:0] vel_x_out,
    output logic [31:0] vel_y_out,
    output logic [9:0]  angle_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_UPD_X   = 3'd2,
        S_UPD_Y   = 3'd3,
        S_UPD_ANG = 3'd4,
        S_WRITE   = 3'd5
    } state_t;

    localparam logic signed [32:0] POS_HI  = 33'(POS_MAX) <<< 25;
    localparam logic signed [32:0] POS_LO  = 33'(POS_MIN) <<< 25;
    localparam logic signed [10:0] ANG_PI  = 11'sd402;
    localparam logic signed [10:0] ANG_2PI = 11'sd804;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               wr_en_q, wr_en_d;
    logic signed [31:0] px_q, px_d, py_q, py_d;
    logic signed [31:0] vx_q, vx_d, vy_q, vy_d;
    logic signed [31:0] delta_q, delta_d;
    logic        [9:0]  ang_q, ang_d, om_q, om_d;
    logic        [31:0] px_out_q, px_out_d, py_out_q, py_out_d;
    logic        [31:0] vx_out_q, vx_out_d, vy_out_q, vy_out_d;
    logic        [9:0]  ang_out_q, ang_out_d;

    logic signed [32:0] add_a, add_b, sum;
    logic signed [31:0] vel_sel, vel_new, pos_new;
    logic signed [10:0] ang_s, ang_w;

    function automatic logic [31:0] sat_neg(input logic [31:0] v);
        return (v == 32'h8000_0000) ? 32'h7FFF_FFFF : (~v + 32'd1);
    endfunction

    // The single adder serves the x, y and angle updates in turn.
    always_comb begin
        add_a = {px_q[31], px_q};
        add_b = {delta_q[31], delta_q};
        case (state_q)
            S_UPD_Y:   add_a = {py_q[31], py_q};
            S_UPD_ANG: begin
                add_a = {{23{ang_q[9]}}, ang_q};
                add_b = {{23{om_q[9]}}, om_q};
            end
            default: ;
        endcase
    end

    assign sum = add_a + add_b;

    // Reflection shared by both axes; only one axis is updated per cycle.
    always_comb begin
        vel_sel = (state_q == S_UPD_Y) ? vy_q : vx_q;
        pos_new = sum[31:0];
        vel_new = vel_sel;
        if (sum > POS_HI) begin
            pos_new = POS_HI[31:0];
            vel_new = sat_neg(vel_sel);
        end else if (sum < POS_LO) begin
            pos_new = POS_LO[31:0];
            vel_new = sat_neg(vel_sel);
        end
    end

    always_comb begin
        ang_s = sum[10:0];
        ang_w = ang_s;
        if (ang_s > ANG_PI)
            ang_w = ang_s - ANG_2PI;
        else if (ang_s < -ANG_PI)
            ang_w = ang_s + ANG_2PI;
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        px_d      = px_q;
        py_d      = py_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        delta_d   = delta_q;
        ang_d     = ang_q;
        om_d      = om_q;
        px_out_d  = px_out_q;
        py_out_d  = py_out_q;
        vx_out_d  = vx_out_q;
        vy_out_d  = vy_out_q;
        ang_out_d = ang_out_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    px_d    = pos_x_in;
                    py_d    = pos_y_in;
                    vx_d    = vel_x_in;
                    vy_d    = vel_y_in;
                    ang_d   = angle_in;
                    om_d    = omega_in;
                    busy_d  = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                delta_d = vx_q >>> (DT_SHIFT + 1);
                state_d = S_UPD_X;
            end
            S_UPD_X: begin
                px_d    = pos_new;
                vx_d    = vel_new;
                delta_d = vy_q >>> (DT_SHIFT + 1);
                state_d = S_UPD_Y;
            end
            S_UPD_Y: begin
                py_d    = pos_new;
                vy_d    = vel_new;
                state_d = S_UPD_ANG;
            end
            S_UPD_ANG: begin
                ang_d   = ang_w[9:0];
                state_d = S_WRITE;
            end
            S_WRITE: begin
                px_out_d  = px_q;
                py_out_d  = py_q;
                vx_out_d  = vx_q;
                vy_out_d  = vy_q;
                ang_out_d = ang_q;
                wr_en_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            delta_q   <= '0;
            ang_q     <= '0;
            om_q      <= '0;
            px_out_q  <= '0;
            py_out_q  <= '0;
            vx_out_q  <= '0;
            vy_out_q  <= '0;
            ang_out_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            px_q      <= px_d;
            py_q      <= py_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            delta_q   <= delta_d;
            ang_q     <= ang_d;
            om_q      <= om_d;
            px_out_q  <= px_out_d;
            py_out_q  <= py_out_d;
            vx_out_q  <= vx_out_d;
            vy_out_q  <= vy_out_d;
            ang_out_q <= ang_out_d;
        end
    end

    assign busy      = busy_q;
    assign wr_en     = wr_en_q;
    assign pos_x_out = px_out_q;
    assign pos_y_out = py_out_q;
    assign vel_x_out = vx_out_q;
    assign vel_y_out = vy_out_q;
    assign angle_out = ang_out_q;

endmodule

`default_nettype wire

// File: tb/tb_obb_integrator.sv
// ============================================================================
// tb_obb_integrator: randomized and directed bench for obb_integrator.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obb_integrator;

    localparam int DT_SHIFT = 6;
    localparam int POS_MIN  = -60;
    localparam int POS_MAX  = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] pos_x_in, pos_y_in, vel_x_in, vel_y_in;
    logic [9:0]  angle_in, omega_in;
    logic        busy, wr_en;
    logic [31:0] pos_x_out, pos_y_out, vel_x_out, vel_y_out;
    logic [9:0]  angle_out;

    int n_checks = 0;
    int n_errors = 0;

    obb_integrator #(
        .DT_SHIFT(DT_SHIFT),
        .POS_MIN (POS_MIN),
        .POS_MAX (POS_MAX)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pos_x_in (pos_x_in),
        .pos_y_in (pos_y_in),
        .vel_x_in (vel_x_in),
        .vel_y_in (vel_y_in),
        .angle_in (angle_in),
        .omega_in (omega_in),
        .busy     (busy),
        .wr_en    (wr_en),
        .pos_x_out(pos_x_out),
        .pos_y_out(pos_y_out),
        .vel_x_out(vel_x_out),
        .vel_y_out(vel_y_out),
        .angle_out(angle_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: real-valued rules expressed as integer arithmetic.
    function automatic longint floor_div(input longint n, input longint m);
        if (n >= 0) return n / m;
        return -((-n + m - 1) / m);
    endfunction

    task automatic model_axis(input logic [31:0] p, input logic [31:0] v,
                              output logic [31:0] po, output logic [31:0] vo);
        longint ps, vs, s, hi, lo, nv;
        ps = longint'($signed(p));
        vs = longint'($signed(v));
        hi = longint'(POS_MAX) * 33554432;
        lo = longint'(POS_MIN) * 33554432;
        s  = ps + floor_div(vs, longint'(1) << (DT_SHIFT + 1));
        nv = -vs;
        if (nv > 64'sd2147483647) nv = 64'sd2147483647;
        if (s > hi) begin
            po = hi[31:0];
            vo = nv[31:0];
        end else if (s < lo) begin
            po = lo[31:0];
            vo = nv[31:0];
        end else begin
            po = s[31:0];
            vo = v;
        end
    endtask

    task automatic model_angle(input logic [9:0] a, input logic [9:0] o, output logic [9:0] ao);
        int s;
        s = int'($signed(a)) + int'($signed(o));
        if (s > 402) s = s - 804;
        else if (s < -402) s = s + 804;
        ao = s[9:0];
    endtask

    task automatic drive(input logic [31:0] px, input logic [31:0] py, input logic [31:0] vx,
                         input logic [31:0] vy, input logic [9:0] a, input logic [9:0] om);
        pos_x_in = px; pos_y_in = py; vel_x_in = vx; vel_y_in = vy;
        angle_in = a;  omega_in = om;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] px, input logic [31:0] py,
                                 input logic [31:0] vx, input logic [31:0] vy,
                                 input logic [9:0] a, input logic [9:0] om);
        logic [31:0] epx, epy, evx, evy;
        logic [9:0]  ea;
        model_axis(px, vx, epx, evx);
        model_axis(py, vy, epy, evy);
        model_angle(a, om, ea);
        chk({tag, ".pos_x"}, pos_x_out, epx);
        chk({tag, ".pos_y"}, pos_y_out, epy);
        chk({tag, ".vel_x"}, vel_x_out, evx);
        chk({tag, ".vel_y"}, vel_y_out, evy);
        chk({tag, ".angle"}, {22'd0, angle_out}, {22'd0, ea});
    endtask

    // One full frame: start at edge N, expect wr_en in cycle N+5 only.
    task automatic run_frame(input string tag, input logic [31:0] px, input logic [31:0] py,
                             input logic [31:0] vx, input logic [31:0] vy,
                             input logic [9:0] a, input logic [9:0] om);
        int lat;
        @(negedge clk);
        drive(px, py, vx, vy, a, om);
        start = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".busy_start"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        drive($urandom, $urandom, $urandom, $urandom, 10'($urandom), 10'($urandom));
        lat = 99;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (wr_en) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'd5);
        chk({tag, ".busy_wr"}, {31'd0, busy}, 32'd1);
        check_outputs(tag, px, py, vx, vy, a, om);
        @(posedge clk); #1;
        chk({tag, ".wr_pulse"}, {31'd0, wr_en}, 32'd0);
        chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int wr_cnt;
        logic [31:0] px, py;
        rst_n = 1'b0;
        start = 1'b0;
        drive('0, '0, '0, '0, '0, '0);

        // Start pulses under reset must be ignored.
        wr_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = (c == 1);
            drive(32'h0100_0000, 32'h0200_0000, 32'h0400_0000, 32'h0400_0000, 10'd5, 10'd5);
            @(posedge clk); #1;
            if (wr_en) wr_cnt++;
        end
        chk("rst.wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.pos_x", pos_x_out, 32'd0);
        chk("rst.vel_y", vel_y_out, 32'd0);
        chk("rst.angle", {22'd0, angle_out}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        run_frame("straight", 32'h0000_0000, 32'h0200_0000, 32'h0400_0000, 32'hFC00_0000, 10'd0, 10'd3);
        chk("straight.pos_x_lit", pos_x_out, 32'h0008_0000);
        chk("straight.pos_y_lit", pos_y_out, 32'h01F8_0000);
        run_frame("upper", 32'h77FF_0000, 32'h0, 32'h7000_0000, 32'h0, 10'd0, 10'd0);
        chk("upper.pos_x_lit", pos_x_out, 32'h7800_0000);
        chk("upper.vel_x_lit", vel_x_out, 32'h9000_0000);
        run_frame("lower_sat", 32'h0, 32'h8800_0000, 32'h0, 32'h8000_0000, 10'd0, 10'd0);
        chk("lower_sat.pos_y_lit", pos_y_out, 32'h8800_0000);
        chk("lower_sat.vel_y_lit", vel_y_out, 32'h7FFF_FFFF);
        run_frame("edge_eq", 32'h77F8_0000, 32'h8808_0000, 32'h0400_0000, 32'hFC00_0000, 10'd0, 10'd0);
        chk("edge_eq.vel_x_lit", vel_x_out, 32'h0400_0000);
        run_frame("ang_pos", 32'h0, 32'h0, 32'h0, 32'h0, 10'd400, 10'd10);
        chk("ang_pos.lit", {22'd0, angle_out}, 32'h276);
        run_frame("ang_neg", 32'h0, 32'h0, 32'h0, 32'h0, 10'h270, 10'h3F6);
        chk("ang_neg.lit", {22'd0, angle_out}, 32'd394);

        for (int i = 0; i < 40; i++) begin
            for (int ax = 0; ax < 2; ax++) begin
                logic [31:0] p;
                case ($urandom_range(0, 3))
                    0: p = $urandom;
                    1: p = 32'h7800_0000 - $urandom_range(0, 32'h0100_0000);
                    2: p = 32'h8800_0000 + $urandom_range(0, 32'h0100_0000);
                    default: p = $urandom_range(0, 32'h0FFF_FFFF) - 32'h0800_0000;
                endcase
                if (ax == 0) px = p; else py = p;
            end
            run_frame("rand", px, py, $urandom, ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                      10'($urandom), 10'($urandom));
        end

        // Start re-pulsed while busy and during WRITE: only frame A is written.
        @(negedge clk);
        drive(32'h0123_4567, 32'hF000_0000, 32'h0100_0000, 32'hFF00_0000, 10'd100, 10'd7);
        start = 1'b1;
        @(posedge clk); #1;
        wr_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = (c == 2) || (c == 5);
            drive(32'h0555_0000, 32'h0666_0000, 32'h0777_0000, 32'h0888_0000, 10'd200, 10'd9);
            @(posedge clk); #1;
            if (wr_en) begin
                wr_cnt++;
                check_outputs("repulse", 32'h0123_4567, 32'hF000_0000, 32'h0100_0000,
                              32'hFF00_0000, 10'd100, 10'd7);
            end
        end
        chk("repulse.wr_cnt", 32'(wr_cnt), 32'd1);
        @(negedge clk);
        start = 1'b0;

        // Reset asserted while the y axis is being updated.
        @(negedge clk);
        drive(32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000, 10'd50, 10'd5);
        start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        wr_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            @(posedge clk); #1;
            if (wr_en) wr_cnt++;
        end
        chk("midrst.wr_cnt", 32'(wr_cnt), 32'd0);
        chk("midrst.busy_after", {31'd0, busy}, 32'd0);
        chk("midrst.pos_x", pos_x_out, 32'd0);
        run_frame("post_rst", 32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000, 10'd50, 10'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
